// File: rtl/i2c_slave_data_unit_if.sv
// Bus-side and byte-side signals of the I2C target data unit.
// The master modport is the bus/system side that drives the target; the slave modport is the target.
`timescale 1ns/1ps
interface i2c_slave_data_unit_if;
   logic       SCL;
   logic       SDA_IN;
   logic       SDA_OE;
   logic [7:0] TxData;
   logic       TxReq;
   logic [7:0] RxData;
   logic       RxValid;
   logic       RW;
   logic       Busy;

   modport master (
      output SCL, SDA_IN, TxData,
      input  SDA_OE, TxReq, RxData, RxValid, RW, Busy
   );

   modport slave (
      input  SCL, SDA_IN, TxData,
      output SDA_OE, TxReq, RxData, RxValid, RW, Busy
   );
endinterface

// File: rtl/i2c_slave_data_unit.sv
// I2C target data unit: oversampled START/STOP detection, 7-bit address match,
// byte receive/transmit with ACK generation and checking. SDA is open-drain via SDA_OE.
`timescale 1ns/1ps
module i2c_slave_data_unit #(
   parameter logic [6:0] ADDRESS = 7'h42
) (
   input logic                  CLK,
   input logic                  RESET,
   i2c_slave_data_unit_if.slave bus
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ADDR      = 3'd1;
   localparam logic [2:0] ADDR_ACK  = 3'd2;
   localparam logic [2:0] WRITE     = 3'd3;
   localparam logic [2:0] WRITE_ACK = 3'd4;
   localparam logic [2:0] READ      = 3'd5;
   localparam logic [2:0] READ_ACK  = 3'd6;
   localparam logic [2:0] WAIT_STOP = 3'd7;

   logic [2:0] sclSync;
   logic [2:0] sdaSync;

   logic [2:0] state,     stateNext;
   logic [2:0] bitCnt,    bitCntNext;
   logic [7:0] shiftReg,  shiftNext;
   logic       byteFull,  byteFullNext;
   logic       sdaOe,     sdaOeNext;
   logic       rwReg,     rwNext;
   logic       busyReg,   busyNext;
   logic [7:0] rxDataReg, rxDataNext;
   logic       rxValid,   rxValidNext;
   logic       txReq,     txReqNext;

   logic sclHigh;
   logic startEv;
   logic stopEv;
   logic sclRise;
   logic sclFall;
   logic sdaBit;

   // Synchronisers idle high so reset release on a quiet bus produces no events.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sclSync <= '1;
         sdaSync <= '1;
      end else begin
         sclSync <= {sclSync[1:0], bus.SCL};
         sdaSync <= {sdaSync[1:0], bus.SDA_IN};
      end
   end

   always_comb begin
      sclHigh = sclSync[1] & sclSync[2];
      startEv = sclHigh & sdaSync[2] & ~sdaSync[1];
      stopEv  = sclHigh & ~sdaSync[2] & sdaSync[1];
      sclRise = sclSync[1] & ~sclSync[2];
      sclFall = ~sclSync[1] & sclSync[2];
      sdaBit  = sdaSync[1];
   end

   // START/STOP require SCL steady high, so they can never coincide with an SCL edge.
   always_comb begin
      stateNext    = state;
      bitCntNext   = bitCnt;
      shiftNext    = shiftReg;
      byteFullNext = byteFull;
      sdaOeNext    = sdaOe;
      rwNext       = rwReg;
      busyNext     = busyReg;
      rxDataNext   = rxDataReg;
      rxValidNext  = 1'b0;
      txReqNext    = 1'b0;

      if (startEv) begin
         stateNext    = ADDR;
         bitCntNext   = '0;
         byteFullNext = 1'b0;
         sdaOeNext    = 1'b0;
      end else if (stopEv) begin
         stateNext    = IDLE;
         bitCntNext   = '0;
         byteFullNext = 1'b0;
         sdaOeNext    = 1'b0;
         busyNext     = 1'b0;
      end else begin
         case (state)
            ADDR: begin
               if (sclRise && !byteFull) begin
                  shiftNext  = {shiftReg[6:0], sdaBit};
                  bitCntNext = bitCnt + 3'd1;
                  if (bitCnt == 3'd7) begin
                     byteFullNext = 1'b1;
                     rwNext       = sdaBit;
                     if ((shiftReg[6:0] == ADDRESS) && sdaBit)
                        txReqNext = 1'b1;
                  end
               end else if (sclFall && byteFull) begin
                  byteFullNext = 1'b0;
                  if (shiftReg[7:1] == ADDRESS) begin
                     sdaOeNext = 1'b1;
                     busyNext  = 1'b1;
                     stateNext = ADDR_ACK;
                  end else begin
                     busyNext  = 1'b0;
                     stateNext = WAIT_STOP;
                  end
               end
            end

            ADDR_ACK: begin
               if (sclFall) begin
                  bitCntNext = '0;
                  if (rwReg) begin
                     shiftNext = bus.TxData;
                     sdaOeNext = ~bus.TxData[7];
                     stateNext = READ;
                  end else begin
                     sdaOeNext = 1'b0;
                     stateNext = WRITE;
                  end
               end
            end

            WRITE: begin
               if (sclRise && !byteFull) begin
                  shiftNext  = {shiftReg[6:0], sdaBit};
                  bitCntNext = bitCnt + 3'd1;
                  if (bitCnt == 3'd7) begin
                     rxDataNext   = {shiftReg[6:0], sdaBit};
                     rxValidNext  = 1'b1;
                     byteFullNext = 1'b1;
                  end
               end else if (sclFall && byteFull) begin
                  byteFullNext = 1'b0;
                  sdaOeNext    = 1'b1;
                  stateNext    = WRITE_ACK;
               end
            end

            WRITE_ACK: begin
               if (sclFall) begin
                  sdaOeNext  = 1'b0;
                  bitCntNext = '0;
                  stateNext  = WRITE;
               end
            end

            // bitCnt counts bits already placed on the bus; bit 7 went out on entry.
            READ: begin
               if (sclFall) begin
                  if (bitCnt == 3'd7) begin
                     sdaOeNext  = 1'b0;
                     bitCntNext = '0;
                     stateNext  = READ_ACK;
                  end else begin
                     shiftNext  = {shiftReg[6:0], 1'b0};
                     sdaOeNext  = ~shiftReg[6];
                     bitCntNext = bitCnt + 3'd1;
                  end
               end
            end

            READ_ACK: begin
               if (sclRise) begin
                  if (!sdaBit) begin
                     txReqNext = 1'b1;
                  end else begin
                     sdaOeNext = 1'b0;
                     busyNext  = 1'b0;
                     stateNext = WAIT_STOP;
                  end
               end else if (sclFall) begin
                  shiftNext  = bus.TxData;
                  sdaOeNext  = ~bus.TxData[7];
                  bitCntNext = '0;
                  stateNext  = READ;
               end
            end

            default: begin
               sdaOeNext = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         bitCnt    <= '0;
         shiftReg  <= '0;
         byteFull  <= 1'b0;
         sdaOe     <= 1'b0;
         rwReg     <= 1'b0;
         busyReg   <= 1'b0;
         rxDataReg <= '0;
         rxValid   <= 1'b0;
         txReq     <= 1'b0;
      end else begin
         state     <= stateNext;
         bitCnt    <= bitCntNext;
         shiftReg  <= shiftNext;
         byteFull  <= byteFullNext;
         sdaOe     <= sdaOeNext;
         rwReg     <= rwNext;
         busyReg   <= busyNext;
         rxDataReg <= rxDataNext;
         rxValid   <= rxValidNext;
         txReq     <= txReqNext;
      end
   end

   assign bus.SDA_OE  = sdaOe;
   assign bus.TxReq   = txReq;
   assign bus.RxData  = rxDataReg;
   assign bus.RxValid = rxValid;
   assign bus.RW      = rwReg;
   assign bus.Busy    = busyReg;

endmodule
